// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with two read ports, one write port and busy-bit scoreboard
// Decode reserves destinations, writeback writes and releases them; hazards drive the pipeline stall.
module reg_file_scoreboard #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] writeAdr,
    input  logic [DATA_W-1:0] writeData,
    input  logic              reserveEn,
    input  logic [ADDR_W-1:0] reserveAdr,
    input  logic [ADDR_W-1:0] readAdr1,
    input  logic [ADDR_W-1:0] readAdr2,
    input  logic              readUse1,
    input  logic              readUse2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              readBusy1,
    output logic              readBusy2,
    output logic              stall,
    output logic [ADDR_W:0]   busyCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_count_q;
    logic [ADDR_W:0]   busy_count_d;

    logic wr_ok;
    logic rsv_ok;
    logic inc;
    logic dec;
    logic zero1;
    logic zero2;
    logic hit1;
    logic hit2;
    logic waw_hazard;

    always_comb begin
        wr_ok  = writeEn && !((ZERO_REG != 0) && (writeAdr == '0));
        rsv_ok = reserveEn && !((ZERO_REG != 0) && (reserveAdr == '0));

        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[writeAdr] = writeData;
        end

        // Reservation is applied after the release so a same-edge new producer keeps the bit set.
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[writeAdr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[reserveAdr] = 1'b1;
        end

        inc = rsv_ok && !busy_q[reserveAdr];
        dec = wr_ok && busy_q[writeAdr] && !(rsv_ok && (reserveAdr == writeAdr));

        busy_count_d = busy_count_q;
        if (inc && !dec) begin
            busy_count_d = busy_count_q + (ADDR_W+1)'(1);
        end else if (dec && !inc) begin
            busy_count_d = busy_count_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        zero1 = (ZERO_REG != 0) && (readAdr1 == '0);
        zero2 = (ZERO_REG != 0) && (readAdr2 == '0);
        hit1  = (BYPASS != 0) && writeEn && (writeAdr == readAdr1) && !zero1;
        hit2  = (BYPASS != 0) && writeEn && (writeAdr == readAdr2) && !zero2;

        readData1 = zero1 ? '0 : (hit1 ? writeData : regs_q[readAdr1]);
        readData2 = zero2 ? '0 : (hit2 ? writeData : regs_q[readAdr2]);
        readBusy1 = busy_q[readAdr1] && !hit1;
        readBusy2 = busy_q[readAdr2] && !hit2;

        // A same-cycle writeback to the reserved address retires the old producer, so no WAW stall.
        waw_hazard = reserveEn && busy_q[reserveAdr] && !(writeEn && (writeAdr == reserveAdr));
        stall      = (readUse1 && readBusy1) || (readUse2 && readBusy2) || waw_hazard;
    end

    assign busyCount = busy_count_q;

endmodule
